// File: rtl/udp_panel_stream_writer.sv
// Framed UDP pixel stream to LED panel framebuffer writes (header word + auto-addressed pixels).
// Optional feature macro: UDP_PANEL_STATS_EN builds the stat_pkts/stat_drops counters.
module udp_panel_stream_writer #(
  parameter logic [7:0] PORT_MSB = 8'h80,
  parameter int         PANELS   = 6,
  parameter int         ADDR_W   = 14,
  parameter int         COLOR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              udp_source_valid,
  input  logic              udp_source_last,
  output logic              udp_source_ready,
  input  logic [15:0]       udp_source_src_port,
  input  logic [15:0]       udp_source_dst_port,
  input  logic [31:0]       udp_source_ip_address,
  input  logic [15:0]       udp_source_length,
  input  logic [31:0]       udp_source_data,
  input  logic [3:0]        udp_source_error,
  input  logic              ctrl_busy,
  output logic [PANELS-1:0] ctrl_en,
  output logic [15:0]       ctrl_addr,
  output logic [23:0]       ctrl_wdat,
  output logic              led_reg,
  output logic [15:0]       stat_pkts,
  output logic [15:0]       stat_drops
);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;

  localparam int SHIFT = 8 - COLOR_W;

  state_t            state_r, state_s;
  logic [PANELS-1:0] mask_r, mask_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [15:0]       count_r, count_s;
  logic              xfer_s, port_match_s, beat_err_s;
  logic              write_s, done_s, drop_s;
  logic              unused_inputs;

  // Keep the top COLOR_W bits of a byte, right-justified in an 8-bit lane.
  function automatic logic [7:0] lane(input logic [7:0] b);
    lane = b >> SHIFT;
  endfunction

  assign xfer_s       = udp_source_valid & udp_source_ready;
  assign port_match_s = (udp_source_dst_port[15:8] == PORT_MSB);
  assign beat_err_s   = (udp_source_error != 4'h0);
  assign unused_inputs = ^{udp_source_src_port, udp_source_ip_address, udp_source_length,
                           udp_source_data[31:24], udp_source_dst_port};

  // Ready depends only on state and backpressure; forced low while reset is held.
  always_comb begin
    if (reset) begin
      udp_source_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE:    udp_source_ready = 1'b1;
        STREAM:  udp_source_ready = ~ctrl_busy;
        DRAIN:   udp_source_ready = 1'b1;
        default: udp_source_ready = 1'b0;
      endcase
    end
  end

  // Packet parser: header decode, pixel accounting and drain of unwanted beats.
  always_comb begin
    state_s = state_r;
    mask_s  = mask_r;
    addr_s  = addr_r;
    count_s = count_r;
    write_s = 1'b0;
    done_s  = 1'b0;
    drop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          if (port_match_s && !beat_err_s && !udp_source_last) begin
            mask_s  = udp_source_dst_port[PANELS-1:0];
            addr_s  = udp_source_data[16 +: ADDR_W];
            count_s = udp_source_data[15:0];
            if (udp_source_data[15:0] == 16'h0) begin
              state_s = DRAIN;
              drop_s  = 1'b1;
            end else begin
              state_s = STREAM;
            end
          end else begin
            state_s = udp_source_last ? IDLE : DRAIN;
            drop_s  = port_match_s && (beat_err_s || (udp_source_data[15:0] == 16'h0));
          end
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (xfer_s) begin
          if (beat_err_s) begin
            drop_s  = 1'b1;
            state_s = udp_source_last ? IDLE : DRAIN;
          end else begin
            write_s = 1'b1;
            addr_s  = addr_r + ADDR_W'(1'b1);
            count_s = count_r - 16'd1;
            if (udp_source_last) begin
              done_s  = 1'b1;
              state_s = IDLE;
            end else if (count_r == 16'd1) begin
              done_s  = 1'b1;
              state_s = DRAIN;
            end else begin
              state_s = STREAM;
            end
          end
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        if (xfer_s && udp_source_last) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, header context and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      mask_r    <= '0;
      addr_r    <= '0;
      count_r   <= 16'h0;
      ctrl_en   <= '0;
      ctrl_addr <= 16'h0;
      ctrl_wdat <= 24'h0;
      led_reg   <= 1'b1;
    end else begin
      state_r <= state_s;
      mask_r  <= mask_s;
      addr_r  <= addr_s;
      count_r <= count_s;
      ctrl_en <= write_s ? mask_r : '0;
      if (write_s) begin
        ctrl_addr <= 16'(addr_r);
        ctrl_wdat <= {lane(udp_source_data[23:16]), lane(udp_source_data[15:8]),
                      lane(udp_source_data[7:0])};
      end
      if (done_s) begin
        led_reg <= ~led_reg;
      end
    end
  end

`ifdef UDP_PANEL_STATS_EN
  // Saturating packet statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pkts  <= 16'h0;
      stat_drops <= 16'h0;
    end else begin
      if (done_s && (stat_pkts != 16'hFFFF)) begin
        stat_pkts <= stat_pkts + 16'd1;
      end
      if (drop_s && (stat_drops != 16'hFFFF)) begin
        stat_drops <= stat_drops + 16'd1;
      end
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_s;
  assign stat_pkts   = 16'h0;
  assign stat_drops  = 16'h0;
`endif

endmodule

// File: tb/tb_udp_panel_stream_writer.sv
// Randomized bench for udp_panel_stream_writer: packet-level reference model, per-cycle compare.
`timescale 1ns/1ps
module tb_udp_panel_stream_writer;
  localparam int         PANELS   = 6;
  localparam int         ADDR_W   = 14;
  localparam int         COLOR_W  = 6;
  localparam logic [7:0] PORT_MSB = 8'h80;
  localparam int         MAXB     = 1024;
`ifdef UDP_PANEL_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic udp_source_valid, udp_source_last, udp_source_ready;
  logic [15:0] udp_source_src_port, udp_source_dst_port, udp_source_length;
  logic [31:0] udp_source_ip_address, udp_source_data;
  logic [3:0]  udp_source_error;
  logic ctrl_busy;
  logic [PANELS-1:0] ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic led_reg;
  logic [15:0] stat_pkts, stat_drops;

  always #5 clk = ~clk;

  udp_panel_stream_writer dut (
    .clk(clk), .reset(reset),
    .udp_source_valid(udp_source_valid), .udp_source_last(udp_source_last),
    .udp_source_ready(udp_source_ready), .udp_source_src_port(udp_source_src_port),
    .udp_source_dst_port(udp_source_dst_port), .udp_source_ip_address(udp_source_ip_address),
    .udp_source_length(udp_source_length), .udp_source_data(udp_source_data),
    .udp_source_error(udp_source_error), .ctrl_busy(ctrl_busy),
    .ctrl_en(ctrl_en), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .led_reg(led_reg), .stat_pkts(stat_pkts), .stat_drops(stat_drops)
  );

  // beat stream and per-beat expectations derived from the packet rules
  logic [15:0] b_port[MAXB];
  logic [31:0] b_data[MAXB];
  logic [3:0]  b_err[MAXB];
  logic        b_last[MAXB];
  logic        e_stream[MAXB], e_wr[MAXB], e_done[MAXB], e_drop[MAXB];
  logic [PANELS-1:0] e_en[MAXB];
  logic [15:0] e_addr[MAXB];
  logic [23:0] e_wdat[MAXB];
  int nb = 0;

  int total = 0, bad = 0;
  int k = 0, hi_k = 0;
  logic pend_v = 1'b0;
  int pend_i = 0;
  logic [15:0] exp_addr = 16'h0;
  logic [23:0] exp_wdat = 24'h0;
  logic exp_led = 1'b1;
  int exp_pkts = 0, exp_drops = 0;
  int ready_low_cnt = 0;
  logic [45:0] wlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] lane8(input logic [7:0] b);
    return 8'(int'(b) / (1 << (8 - COLOR_W)));
  endfunction

  function automatic logic [15:0] stat_exp(input int v);
    return STATS_ON ? 16'(v) : 16'h0;
  endfunction

  function automatic logic [45:0] wentry(input int i);
    return (i < wlog.size()) ? wlog[i] : {46{1'b1}};
  endfunction

  function automatic void add_beat(input logic [15:0] port, input logic [31:0] data,
                                   input logic [3:0] err, input logic last);
    b_port[nb] = port; b_data[nb] = data; b_err[nb] = err; b_last[nb] = last;
    nb++;
  endfunction

  // Split beats into packets at 'last' and work out what each packet must do.
  task automatic analyze(input int lo, input int hi);
    int p, q, n, cnt, base;
    logic [PANELS-1:0] m;
    bit match;
    p = lo;
    while (p < hi) begin
      q = p;
      while (q < hi - 1 && !b_last[q]) q++;
      for (int i = p; i <= q; i++) begin
        e_stream[i] = 1'b0; e_wr[i] = 1'b0; e_done[i] = 1'b0; e_drop[i] = 1'b0;
        e_en[i] = '0; e_addr[i] = 16'h0; e_wdat[i] = 24'h0;
      end
      match = (b_port[p][15:8] == PORT_MSB);
      cnt   = int'(b_data[p][15:0]);
      base  = int'(b_data[p] >> 16) % (1 << ADDR_W);
      m     = b_port[p][PANELS-1:0];
      if (match && b_err[p] == 4'h0 && !b_last[p] && cnt != 0) begin
        n = 0;
        for (int i = p + 1; i <= q; i++) begin
          e_stream[i] = 1'b1;
          if (b_err[i] != 4'h0) begin
            e_drop[i] = 1'b1;
            break;
          end
          e_wr[i]   = 1'b1;
          e_en[i]   = m;
          e_addr[i] = 16'((base + n) % (1 << ADDR_W));
          e_wdat[i] = {lane8(b_data[i][23:16]), lane8(b_data[i][15:8]), lane8(b_data[i][7:0])};
          n++;
          if (n == cnt || i == q) begin
            e_done[i] = 1'b1;
            break;
          end
        end
      end else if (match && (b_err[p] != 4'h0 || cnt == 0)) begin
        e_drop[p] = 1'b1;
      end
      p = q + 1;
    end
  endtask

  // Called at each negedge: outputs vs model, then record this cycle's transfer.
  task automatic check_cycle();
    logic [PANELS-1:0] een;
    logic exp_rdy;
    een = '0;
    if (pend_v) begin
      if (e_wr[pend_i]) begin
        een = e_en[pend_i]; exp_addr = e_addr[pend_i]; exp_wdat = e_wdat[pend_i];
      end
      if (e_done[pend_i]) begin
        if (exp_pkts < 65535) exp_pkts++;
        exp_led = ~exp_led;
      end
      if (e_drop[pend_i] && exp_drops < 65535) exp_drops++;
    end
    chk("ctrl_en", ctrl_en, een);
    chk("ctrl_addr", ctrl_addr, exp_addr);
    chk("ctrl_wdat", ctrl_wdat, exp_wdat);
    chk("led_reg", led_reg, exp_led);
    chk("stat_pkts", stat_pkts, stat_exp(exp_pkts));
    chk("stat_drops", stat_drops, stat_exp(exp_drops));
    if (ctrl_en != '0) wlog.push_back({ctrl_en, ctrl_addr, ctrl_wdat});
    exp_rdy = !((k < hi_k) && e_stream[k] && ctrl_busy);
    chk("ready", udp_source_ready, exp_rdy);
    if (!udp_source_ready) ready_low_cnt++;
    pend_v = udp_source_valid && udp_source_ready && (k < hi_k);
    pend_i = k;
  endtask

  // Offer beats lo..hi-1; rnd selects random valid/busy, else a fixed gap+busy window.
  task automatic run(input int lo, input int hi, input bit rnd, input int gap_at);
    int c;
    logic v, want_busy;
    c = 0; k = lo; hi_k = hi;
    while (k < hi && c < 8000) begin
      if (rnd) begin
        v = ($urandom_range(0, 3) != 0);
        want_busy = ($urandom_range(0, 3) == 0);
      end else begin
        v = (c != gap_at);
        want_busy = (c > gap_at) && (c <= gap_at + 3);
      end
      ctrl_busy = want_busy && (ctrl_en == '0);
      udp_source_valid    = v;
      udp_source_dst_port = b_port[k];
      udp_source_data     = b_data[k];
      udp_source_error    = b_err[k];
      udp_source_last     = b_last[k];
      @(negedge clk); check_cycle();
      @(posedge clk); #1;
      if (pend_v) k++;
      c++;
    end
    chk("run_timeout", 64'(k), 64'(hi));
    udp_source_valid = 1'b0;
    ctrl_busy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      udp_source_valid = 1'b0; ctrl_busy = 1'b0;
      @(negedge clk); check_cycle();
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, udp_source_ready, 1'b0);
    chk({tag, "_en"}, ctrl_en, 6'h00);
    chk({tag, "_addr"}, ctrl_addr, 16'h0);
    chk({tag, "_wdat"}, ctrl_wdat, 24'h0);
    chk({tag, "_led"}, led_reg, 1'b1);
    chk({tag, "_pkts"}, stat_pkts, 16'h0);
    chk({tag, "_drops"}, stat_drops, 16'h0);
  endtask

  initial begin
    int lo, l0, pcount;
    logic [15:0] port;
    logic [31:0] hdr;
    int npix;
    reset = 1'b1; udp_source_valid = 1'b0; udp_source_last = 1'b0; ctrl_busy = 1'b0;
    udp_source_src_port = 16'h1234; udp_source_ip_address = 32'hC0A8_0001;
    udp_source_length = 16'h0040; udp_source_dst_port = 16'h0; udp_source_data = 32'h0;
    udp_source_error = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    reset = 1'b0;

    // P1: basic three-pixel packet
    add_beat(16'h8005, 32'h0010_0003, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h00FF_8040, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0000_0000, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h00FF_FFFF, 4'h0, 1'b1);
    analyze(0, nb);
    chk("model_wdat", e_wdat[1], 24'h3F2010);
    chk("model_addr", e_addr[3], 16'h0012);
    run(0, nb, 1'b0, -10);
    idle(2);
    chk("p1_led", led_reg, 1'b0);
    chk("p1_nwr", 64'(wlog.size()), 64'd3);
    chk("p1_w0", wentry(0), {6'b000101, 16'h0010, 24'h3F2010});
    chk("p1_w1", wentry(1), {6'b000101, 16'h0011, 24'h000000});
    chk("p1_w2", wentry(2), {6'b000101, 16'h0012, 24'h3F3F3F});
    chk("p1_pkts", stat_pkts, STATS_ON ? 16'd1 : 16'd0);

    // P2 wrap, P3 foreign port, P4 errored pixel
    lo = nb;
    add_beat(16'h8005, 32'h3FFF_0002, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0012_3456, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h00AB_CDEF, 4'h0, 1'b1);
    add_beat(16'h7F01, 32'h0010_0003, 4'h0, 1'b0);
    add_beat(16'h7F01, 32'h0011_1111, 4'h0, 1'b0);
    add_beat(16'h7F01, 32'h0022_2222, 4'h0, 1'b0);
    add_beat(16'h7F01, 32'h0033_3333, 4'h0, 1'b1);
    add_beat(16'h8005, 32'h0020_0005, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0010_2030, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0055_5555, 4'h1, 1'b0);
    add_beat(16'h8005, 32'h0066_6666, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0077_7777, 4'h0, 1'b1);
    analyze(lo, nb);
    run(lo, nb, 1'b0, -10);
    // P5 with a valid gap then three busy cycles mid-stream
    lo = nb;
    add_beat(16'h8005, 32'h0030_0002, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0040_4040, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0080_8080, 4'h0, 1'b1);
    analyze(lo, nb);
    ready_low_cnt = 0;
    run(lo, nb, 1'b0, 2);
    chk("busy_ready_low", 64'(ready_low_cnt), 64'd3);
    // P6 long packet: two writes, excess drained
    lo = nb;
    add_beat(16'h8005, 32'h0040_0002, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h00FC_FCFC, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0004_0404, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0099_9999, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0088_8888, 4'h0, 1'b1);
    analyze(lo, nb);
    run(lo, nb, 1'b0, -10);
    idle(2);
    chk("dir_nwr", 64'(wlog.size()), 64'd10);
    chk("wrap_w3", wentry(3), {6'h05, 16'h3FFF, 24'h040D15});
    chk("wrap_w4", wentry(4), {6'h05, 16'h0000, 24'h2A333B});
    chk("err_w5", wentry(5), {6'h05, 16'h0020, 24'h04080C});
    chk("busy_w6", wentry(6), {6'h05, 16'h0030, 24'h101010});
    chk("busy_w7", wentry(7), {6'h05, 16'h0031, 24'h202020});
    chk("long_w8", wentry(8), {6'h05, 16'h0040, 24'h3F3F3F});
    chk("long_w9", wentry(9), {6'h05, 16'h0041, 24'h010101});
    chk("dir_pkts", stat_pkts, STATS_ON ? 16'd4 : 16'd0);
    chk("dir_drops", stat_drops, STATS_ON ? 16'd1 : 16'd0);
    chk("dir_led", led_reg, 1'b1);

    // randomized packets
    lo = nb;
    pcount = 60;
    for (int p = 0; p < pcount; p++) begin
      port = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {8'h80, 8'($urandom)};
      hdr = $urandom;
      hdr[15:0] = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) hdr[29:16] = 14'h3FFE;
      npix = $urandom_range(0, 8);
      add_beat(port, hdr, ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
               npix == 0);
      for (int i = 0; i < npix; i++) begin
        add_beat(port, $urandom,
                 ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                 i == npix - 1);
      end
    end
    analyze(lo, nb);
    run(lo, nb, 1'b1, -10);
    idle(3);

    // reset mid-packet; the remainder is parsed as fresh packets
    lo = nb;
    add_beat(16'h8005, 32'h0040_0002, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h00FF_8040, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h00FF_8040, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0008_0808, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h0010_1010, 4'h0, 1'b1);
    add_beat(16'h8005, 32'h0050_0001, 4'h0, 1'b0);
    add_beat(16'h8005, 32'h00FF_FFFF, 4'h0, 1'b1);
    analyze(lo, nb);
    run(lo, lo + 2, 1'b0, -10);
    idle(1);
    #3 reset = 1'b1;
    #1;
    chk_reset_values("midrst");
    exp_addr = 16'h0; exp_wdat = 24'h0; exp_led = 1'b1;
    exp_pkts = 0; exp_drops = 0; pend_v = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    analyze(lo + 2, nb);
    chk("model_rst_addr", e_addr[lo + 3], 16'h00FF);
    l0 = wlog.size();
    run(lo + 2, nb, 1'b0, -10);
    idle(2);
    chk("rst_w0", wentry(l0), {6'h05, 16'h00FF, 24'h020202});
    chk("rst_w1", wentry(l0 + 1), {6'h05, 16'h0100, 24'h040404});
    chk("rst_w2", wentry(l0 + 2), {6'h05, 16'h0050, 24'h3F3F3F});
    chk("rst_pkts", stat_pkts, STATS_ON ? 16'd2 : 16'd0);
    chk("rst_led", led_reg, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_panel_stream_writer.md
# udp_panel_stream_writer

Streams pixel data from the UDP core's receive port into the LED panel controller's write interface. It supersedes the one-word-per-beat writer with a framed packet format: a header word sets the base address and pixel count, then each following beat writes one pixel at an auto-incrementing address. Panel count, address width and colour depth are parametrised, backpressure from the panel controller is honoured, and malformed or errored packets are dropped cleanly. It sits between the UDP receive stream and the panel framebuffer write ports.

## Interface
- PORT_MSB, 8'h80, required value of udp_source_dst_port[15:8] for a packet to be accepted
- PANELS, 6, number of panels; width of ctrl_en; 1..16
- ADDR_W, 14, framebuffer address width; 1..16
- COLOR_W, 6, bits per colour channel; 1..8

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- udp_source_valid  in  1  beat valid
- udp_source_last  in  1  final beat of packet
- udp_source_ready  out  1  beat accepted when valid & ready
- udp_source_src_port  in  16  unused
- udp_source_dst_port  in  16  [15:8] port match; [PANELS-1:0] panel enable mask
- udp_source_ip_address  in  32  unused
- udp_source_length  in  16  unused
- udp_source_data  in  32  header or pixel word
- udp_source_error  in  4  nonzero marks the beat errored
- ctrl_busy  in  1  panel controller cannot take a write this cycle
- ctrl_en  out  PANELS  per-panel write strobe, one cycle
- ctrl_addr  out  16  write address, zero-extended from ADDR_W
- ctrl_wdat  out  24  {R,G,B} in 8-bit lanes; each lane holds COLOR_W bits right-justified, upper bits zero
- led_reg  out  1  activity indicator
- stat_pkts  out  16  completed packets
- stat_drops  out  16  dropped packets

## Operation
- Reset: udp_source_ready=0, ctrl_en=0, ctrl_addr=0, ctrl_wdat=0, led_reg=1, stat_*=0, state IDLE.
- A transfer occurs when udp_source_valid & udp_source_ready.
- States:
  - IDLE: ready=1. On the first transfer of a packet:
    - If dst_port[15:8]==PORT_MSB, error==0 and last==0: latch mask=dst_port[PANELS-1:0], addr=data[16+ADDR_W-1:16] and count=data[15:0]. Go to STREAM, or to DRAIN if count==0.
    - Otherwise: if last==1 stay in IDLE; else go to DRAIN. A non-matching port does not count as a drop; error or count==0 does.
  - STREAM: ready=~ctrl_busy. Each transfer with error==0 writes the pixel:
    - ctrl_en=mask, ctrl_addr=addr.
    - Each lane = top COLOR_W bits of the corresponding byte: R from data[23:16], G from [15:8], B from [7:0]. data[31:24] is ignored.
    - Then addr increments, wrapping modulo 2^ADDR_W, and count decrements.
    - Errored beat: no write, increment stat_drops, go to DRAIN (or IDLE if last).
    - Last beat with count>1 (short packet): write it, then go to IDLE; counts as completed.
    - count reaches 0 with last==0 (long packet): go to DRAIN; excess beats are discarded; counts as completed.
    - count reaches 0 with last==1: go to IDLE; counts as completed.
  - DRAIN: ready=1; discard beats until a transfer with last==1, then go to IDLE.
- Completed packet: stat_pkts increments (saturating at 16'hFFFF) and led_reg toggles.
- Dropped packet: stat_drops increments, saturating at 16'hFFFF.
- Outside write cycles ctrl_en=0. ctrl_addr and ctrl_wdat hold their last values.

## Timing
- udp_source_ready is combinational from state and ctrl_busy. No combinational path from valid or data to ready.
- Write latency: one cycle. A pixel transferred in cycle N appears as ctrl_en/addr/wdat in cycle N+1.
- ctrl_busy is sampled in the transfer cycle. The bench must not assert ctrl_busy in the cycle a write is presented; the block never holds a write.
- Back-to-back packets: a header may be accepted the cycle after the previous last beat. Maximum throughput is one pixel per cycle.
- Header beat: no write; ctrl_en=0 the following cycle.
- Reset asserted mid-packet: immediate return to reset values; the remainder of the in-flight packet is treated as new packets, i.e. its next beat is parsed as a header.

## Configuration
- UDP_PANEL_STATS_EN defined: stat_pkts and stat_drops counters are implemented as described.
- UDP_PANEL_STATS_EN undefined: both ports are present but tied to 16'h0; no counter logic. All other behaviour is unchanged.

## Test plan
- Port 0x8005, header 0x0010_0003, then three pixels 0x00FF8040, 0x00000000, 0x00FFFFFF with last on the third -> three writes, ctrl_en=6'b000101, addrs 0x10/0x11/0x12; first wdat=24'h3F_20_10 (COLOR_W=6); stat_pkts=1; led_reg toggles to 0.
- Header base 0x3FFF, count 2 (ADDR_W=14) -> writes at 0x3FFF then 0x0000.
- Port 0x7F01 packet of 4 beats -> no writes, stat_pkts and stat_drops unchanged, ready high throughout.
- Header count 5, error=4'h1 on the 2nd pixel, last on the 4th -> one write only, stat_drops=1, next packet processed normally.
- ctrl_busy held high for 3 cycles mid-stream -> ready low for those cycles, no beats lost, addresses contiguous.
- Header count 2 followed by 4 pixels -> two writes, remaining two drained, stat_pkts=1; reset pulsed mid-stream -> all outputs return to reset values within the same cycle.
